// File: rtl/mp3_btn_pkg.sv
// Shared types for the MP3 player button front end.
// Optional auto-repeat is enabled with `define BTN_AUTOREPEAT_EN.
package mp3_btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int SYNC_DEPTH = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: two-flop synchroniser, debounce FSM, registered pulses.
// Auto-repeat hold timer is built only with `define BTN_AUTOREPEAT_EN.
module btn_debounce_cell
  import mp3_btn_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 20000,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int CW =
    $clog2(max3(DEBOUNCE_CNT, REPEAT_DELAY, REPEAT_RATE)) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CNT - 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync;
  btn_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  level_d, press_d, release_d, repeat_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);
  logic [CW-1:0] hold_q, hold_d;
  logic          rep_q, rep_d;
`endif

  assign sync = sync_q[SYNC_DEPTH-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    hold_d    = hold_q;
    rep_d     = rep_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          hold_d  = '0;
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          // first repeat after the delay, then at the faster rate
          if (hold_q == (rep_q ? RR_LAST : RD_LAST)) begin
            press_d  = 1'b1;
            repeat_d = 1'b1;
            hold_d   = '0;
            rep_d    = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      hold_q      <= '0;
      rep_q       <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[SYNC_DEPTH-2:0], btn_raw};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_repeat  <= repeat_d;
`ifdef BTN_AUTOREPEAT_EN
      hold_q      <= hold_d;
      rep_q       <= rep_d;
`endif
    end
  end

endmodule

// File: rtl/button_debounce_ctrl.sv
// Board push-button front end: NUM_BTN independent debounce cells.
// Optional auto-repeat is enabled with `define BTN_AUTOREPEAT_EN.
module button_debounce_ctrl
  import mp3_btn_pkg::*;
#(
  parameter int NUM_BTN      = 4,
  parameter int DEBOUNCE_CNT = 20000,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               any_press
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce_cell #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

  // OR of registered pulses lines up with btn_press in the same cycle
  assign any_press = |btn_press;

endmodule
